// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, credit-limited in-order memory requests, return FIFO and redirect flush.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module instr_fetch #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              pcsrc,
    input  logic [ADDR_W-1:0] pc_target
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed,
    output logic [31:0]       perf_stall
`endif
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0]   DEPTH_WIDE = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     stale_q, stale_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

    logic [31:0]       data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];

    logic              redirect, fifo_empty, credit_ok, issue, rsp_live, push, pop, drop_flush;
    logic [ADDR_W-1:0] target_aligned;

    assign target_aligned = pc_target & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign redirect   = pcsrc && (state_q != IDLE);
    assign fifo_empty = (cnt_q == '0);
    assign credit_ok  = ({1'b0, cnt_q} + {1'b0, out_q}) < DEPTH_WIDE;
    assign imem_req   = (state_q == RUN) && !redirect && credit_ok;
    assign imem_addr  = pc_q;
    assign issue      = imem_req && imem_gnt;
    // A response only counts when a request is actually in flight; this masks strays after reset.
    assign rsp_live   = imem_rvalid && (state_q == RUN) && (out_q != '0);
    assign push       = rsp_live && !redirect;
    assign pop        = instr_valid && instr_ready && !redirect;
    assign drop_flush = imem_rvalid && (state_q == FLUSH) && (stale_q != '0);

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? '0 : data_mem[rd_ptr_q];
    assign instr_pc    = fifo_empty ? '0 : pc_mem[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        out_d     = out_q;
        stale_d   = stale_q;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (redirect) begin
            pc_d      = target_aligned;
            resp_pc_d = target_aligned;
            cnt_d     = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            out_d     = '0;
            if (state_q == RUN) stale_d = out_q - CW'(rsp_live);
            else                stale_d = stale_q - CW'(drop_flush);
            state_d = (stale_d != '0) ? FLUSH : RUN;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (issue) pc_d = pc_q + ADDR_W'(4);
                    out_d = out_q + CW'(issue) - CW'(push);
                    cnt_d = cnt_q + CW'(push) - CW'(pop);
                    if (push) begin
                        wr_ptr_d  = wr_ptr_q + PW'(1);
                        resp_pc_d = resp_pc_q + ADDR_W'(4);
                    end
                    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
                end
                FLUSH: begin
                    if (drop_flush) stale_d = stale_q - CW'(1);
                    if (stale_d == '0) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            stale_q   <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            stale_q   <= stale_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage carries no reset; the outputs are gated by the occupancy count instead.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(push && !pop && (cnt_q == DEPTH_C)));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, flushed_q, stall_q;
    logic [31:0] flush_inc;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        flush_inc = 32'(drop_flush);
        if (redirect) flush_inc = flush_inc + 32'(cnt_q) + 32'(rsp_live);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= sat_add(fetched_q, 32'(pop));
            flushed_q <= sat_add(flushed_q, flush_inc);
            stall_q   <= sat_add(stall_q, 32'(instr_ready && !instr_valid));
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
    assign perf_stall   = stall_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: issue addresses and delivered instructions are checked against queues.
`timescale 1ns/1ps
module tb_instr_fetch;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, imem_gnt, imem_rvalid, instr_ready, pcsrc;
    logic [31:0] imem_rdata, pc_target;
    logic        imem_req, instr_valid, imem_req2, instr_valid2;
    logic [31:0] imem_addr, instr, instr_pc, imem_addr2, instr2, instr_pc2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] pf_fetched, pf_flushed, pf_stall, pf2_fetched, pf2_flushed, pf2_stall;
`endif

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .pcsrc(pcsrc), .pc_target(pc_target)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(pf_fetched), .perf_flushed(pf_flushed), .perf_stall(pf_stall)
`endif
    );

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
        .instr_ready(instr_ready), .pcsrc(pcsrc), .pc_target(pc_target)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(pf2_fetched), .perf_flushed(pf2_flushed), .perf_stall(pf2_stall)
`endif
    );

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_issued = 0;
    int          pc_mode = 0;
    logic        pc_hit = 1'b0;
    logic        force_rv = 1'b0;
    logic        gnt_s = 1'b0, ready_s = 1'b0;
    logic [31:0] target_s = '0;
    int          due_q[$];
    logic [31:0] maddr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_iss_q[$];
    logic [31:0] exp_iss2_q[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One bench cycle: apply inputs at the falling edge, then sample what the DUT will see at the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        imem_gnt    = gnt_s;
        instr_ready = ready_s;
        pc_target   = target_s;
        if (force_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_BAD0;
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(maddr_q[0]);
            void'(due_q.pop_front());
            void'(maddr_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        pcsrc = (pc_mode == 1) || (pc_mode == 2 && imem_rvalid && instr_valid);
        if (pcsrc) pc_hit = 1'b1;
        #1;
        if (imem_req && imem_gnt) begin
            n_issued++;
            if (exp_iss_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_issue: got addr %h, no issue expected", imem_addr);
            end else check("issue_addr", imem_addr, exp_iss_q.pop_front());
            if (exp_iss2_q.size() > 0) begin
                check("dut2_issue_req", 32'(imem_req2), 32'd1);
                check("dut2_issue_addr", imem_addr2, exp_iss2_q.pop_front());
            end
            due_q.push_back(cyc + lat);
            maddr_q.push_back(imem_addr);
        end
    endtask

    task automatic run_issues(input int target);
        int guard;
        guard = 0;
        gnt_s = 1'b1;
        while (n_issued < target && guard < 200) begin
            tick();
            guard++;
        end
        if (n_issued < target) begin
            checks++;
            $display("FAIL issue_timeout: got %0d issues, expected %0d", n_issued, target);
        end
        gnt_s = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        gnt_s = 1'b0;
        while ((due_q.size() > 0 || instr_valid) && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", guard);
        end
        tick();
        check("expected_pops_left", 32'(exp_pc_q.size()), 32'd0);
        check("expected_issues_left", 32'(exp_iss_q.size()), 32'd0);
    endtask

    task automatic expect_range(input logic [31:0] first, input int n, input logic to_pops);
        for (int i = 0; i < n; i++) begin
            exp_iss_q.push_back(first + 32'(4 * i));
            if (to_pops) exp_pc_q.push_back(first + 32'(4 * i));
        end
    endtask

    // Monitor: every accepted pop is compared with the oldest expected delivery.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && instr_valid && instr_ready && !pcsrc) begin
                if (exp_pc_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_pop: got pc %h, no delivery expected", instr_pc);
                end else begin
                    e = exp_pc_q.pop_front();
                    check("pop_pc", instr_pc, e);
                    check("pop_instr", instr, word_of(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; pcsrc = 1'b0; pc_target = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_pc", imem_addr, 32'h0000_0000);
        check("rst_pc_dut2", imem_addr2, 32'hFFFF_FFFC);

        // Stall from reset: only two credits, PC freezes at 8 (dut2 wraps FFFF_FFFC -> 0 -> 4).
        exp_iss_q.push_back(32'h0);
        exp_iss_q.push_back(32'h4);
        exp_iss2_q.push_back(32'hFFFF_FFFC);
        exp_iss2_q.push_back(32'h0000_0000);
        ready_s = 1'b0;
        gnt_s   = 1'b1;
        reset   = 1'b0;
        #1;
        check("idle_no_req", 32'(imem_req), 32'd0);
        base = n_issued;
        repeat (6) tick();
        check("stall_issue_count", 32'(n_issued - base), 32'd2);
        check("stall_req_low", 32'(imem_req), 32'd0);
        check("stall_pc_frozen", imem_addr, 32'h8);
        check("stall_valid", 32'(instr_valid), 32'd1);
        check("stall_head_pc", instr_pc, 32'h0);
        check("dut2_pc_frozen", imem_addr2, 32'h4);
        check("dut2_valid", 32'(instr_valid2), 32'd1);
        check("dut2_head_pc", instr_pc2, 32'hFFFF_FFFC);
        check("dut2_head_instr", instr2, word_of(32'h0));

        // Release the stall and stream up to address 0x24.
        exp_pc_q.push_back(32'h0);
        exp_pc_q.push_back(32'h4);
        expect_range(32'h8, 8, 1'b1);
        ready_s = 1'b1;
        run_issues(10);
        drain();

        // Redirect with two requests in flight (latency 3): both responses must be discarded.
        lat = 3;
        exp_iss_q.push_back(32'h28);
        exp_iss_q.push_back(32'h2C);
        gnt_s = 1'b1;
        base = n_issued;
        tick();
        tick();
        check("two_outstanding", 32'(n_issued - base), 32'd2);
        pc_mode  = 1;
        target_s = 32'h0000_0103;
        tick();
        pc_mode = 0;
        check("redirect_req_low", 32'(imem_req), 32'd0);
        tick();
        check("flush_req_low", 32'(imem_req), 32'd0);
        check("redirect_pc", imem_addr, 32'h0000_0100);
        tick();
        check("flush_hold", 32'(imem_req), 32'd0);
        expect_range(32'h100, 4, 1'b1);
        base = n_issued;
        tick();
        check("flush_exit_issue", 32'(n_issued - base), 32'd1);
        run_issues(base + 4);
        drain();

        // Redirect coinciding with a response and a pop: nothing left stale, fetch resumes at once.
        lat = 2;
        expect_range(32'h110, 2, 1'b0);
        expect_range(32'h200, 4, 1'b1);
        base     = n_issued;
        target_s = 32'h0000_0200;
        pc_hit   = 1'b0;
        pc_mode  = 2;
        gnt_s    = 1'b1;
        for (int g = 0; g < 20 && !pc_hit; g++) tick();
        pc_mode = 0;
        check("coincident_redirect_seen", 32'(pc_hit), 32'd1);
        tick();
        check("redirect_fifo_cleared", 32'(instr_valid), 32'd0);
        check("no_stale_req", 32'(imem_req), 32'd1);
        check("redirect_addr", imem_addr, 32'h0000_0200);
        run_issues(base + 6);
        drain();

        // Fill the FIFO, then reset mid-stream and inject stray responses.
        lat = 1;
        ready_s = 1'b0;
        expect_range(32'h210, 2, 1'b0);
        base = n_issued;
        run_issues(base + 2);
        repeat (3) tick();
        check("prereset_valid", 32'(instr_valid), 32'd1);
        check("prereset_head", instr_pc, 32'h0000_0210);
        @(negedge clk);
        reset = 1'b1;
        imem_gnt = 1'b0; pcsrc = 1'b0; imem_rvalid = 1'b0;
        #1;
        check("midreset_valid", 32'(instr_valid), 32'd0);
        check("midreset_req", 32'(imem_req), 32'd0);
        check("midreset_pc", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched_rst", pf_fetched, 32'd0);
        check("perf_flushed_rst", pf_flushed, 32'd0);
        check("perf_stall_rst", pf_stall, 32'd0);
        check("perf2_sum_rst", pf2_fetched | pf2_flushed | pf2_stall, 32'd0);
`endif
        due_q.delete();
        maddr_q.delete();
        repeat (2) @(negedge clk);
        #1;
        expect_range(32'h0, 4, 1'b1);
        ready_s     = 1'b1;
        gnt_s       = 1'b1;
        force_rv    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        reset       = 1'b0;
        #1;
        check("postreset_idle", 32'(imem_req), 32'd0);
        base = n_issued;
        tick();
        force_rv = 1'b0;
        check("postreset_first_issue", 32'(n_issued - base), 32'd1);
        run_issues(base + 4);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the single-cycle controller/datapath.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned words in a small FIFO and presents them as instr/instr_valid to decode (controller consumes instr[31:12]).
- On PCSrc redirect, flushes the FIFO and discards in-flight stale responses.

Parameters:
- ADDR_W, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >=2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  request valid to instruction memory.
- imem_addr  output  ADDR_W  word-aligned request address (bits[1:0]=0).
- imem_gnt  input  1  memory accepts request this cycle (imem_req & imem_gnt = issue).
- imem_rvalid  input  1  response valid; responses in issue order, latency >=1 cycle.
- imem_rdata  input  32  response instruction word.
- instr_valid  output  1  instr/instr_pc hold a valid instruction.
- instr  output  32  instruction word to controller/datapath.
- instr_pc  output  ADDR_W  address of instr.
- instr_ready  input  1  decode consumes instr this cycle (instr_valid & instr_ready = pop).
- pcsrc  input  1  redirect request (controller PCSrc), single-cycle pulse.
- pc_target  input  ADDR_W  redirect address; bits[1:0] ignored and forced to 0.

Behaviour:
- Reset (async): PC=RESET_PC, FIFO empty, outstanding=0, stale=0, state=IDLE; imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- FSM states:
  - IDLE: one cycle after reset release -> RUN.
  - RUN: normal fetch.
  - FLUSH: wait for stale responses to drain.
- Issue rule (RUN only): imem_req=1 when fifo_count + outstanding < FIFO_DEPTH; imem_addr=PC. On issue: PC+=4 (wraps modulo 2^ADDR_W), outstanding+=1.
- Response (state RUN, stale=0): push {imem_rdata, addr}; the FIFO tracks the issue address per entry. outstanding-=1. Credit rule guarantees no overflow; a push to a full FIFO is a design error (assertion).
- Output: instr/instr_pc = FIFO head, combinational from registered storage; instr_valid = !empty. Pop on instr_valid & instr_ready. Push+pop in the same cycle allowed at any occupancy, count unchanged.
- Latency: issue at cycle N, rvalid at N+k -> instr_valid at N+k+1 if the FIFO was empty.
- Redirect (pcsrc=1, any state except IDLE):
  - FIFO cleared.
  - PC=pc_target&~3.
  - stale = outstanding minus any response arriving that same cycle; that response is dropped.
  - outstanding reset to 0.
  - imem_req forced 0 that cycle.
  - Next state FLUSH if stale>0, else RUN.
  - pcsrc with simultaneous pop: pop ignored (FIFO cleared).
- FLUSH: imem_req=0; each imem_rvalid is dropped and stale-=1; at stale reaching 0 -> RUN. A new pcsrc in FLUSH re-targets PC and stays in FLUSH.
- instr_ready=0: FIFO holds; fetch stalls once credits are exhausted; PC frozen.
- Reset mid-operation: all state cleared immediately; memory responses after reset release with no matching issue are ignored (outstanding=0 masks rvalid).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds output ports:
  - perf_fetched (32): pops, count of instructions delivered.
  - perf_flushed (32): FIFO entries discarded plus stale responses dropped.
  - perf_stall (32): cycles with instr_ready=1 and instr_valid=0.
- All three counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent; other behaviour is identical.

Test Plan:
- Reset release, imem_gnt=1, 1-cycle latency, instr_ready=1, rdata=addr-derived -> imem_addr 0,4,8,...; instr_pc 0,4,8 back-to-back with instr_valid continuous after the first fill.
- instr_ready=0 for 6 cycles -> exactly FIFO_DEPTH (2) issues, FIFO full, PC=8 frozen; release -> instr_pc 0 then 4, fetch resumes at 8.
- With 2 outstanding (latency 3), pulse pcsrc with pc_target=32'h0000_0103 -> PC=32'h100, state FLUSH, two stale responses dropped, next delivered instr_pc=32'h100.
- pcsrc in the same cycle as imem_rvalid and instr pop -> response dropped, FIFO empty next cycle, stale counts only the remaining in-flight request.
- PC wrap: RESET_PC=32'hFFFF_FFFC -> addresses FFFF_FFFC then 0000_0000.
- Assert reset mid-stream with FIFO holding 2 entries -> instr_valid=0 immediately; after release, first request at RESET_PC; a late rvalid is ignored (FETCH_PERF_CNT_EN: counters read 0).
